// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, legal-op bound and the arbiter FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110
  } alu_op_e;

  // Highest legal ALUControl code; anything above is forced to 0 by the ALU.
  localparam logic [3:0] ALU_OP_MAX = 4'(ALU_SRL);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request searching upward from last_grant+1, wrapping.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  // Scan N positions starting just past the previous winner; first hit wins.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_grant) + k) % N;
      if (!grant_any && req[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, one op in flight,
// registered ALU inputs during EXEC, registered response held until accepted.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        ReqValid,
  output logic [NUM_REQ-1:0]        ReqReady,
  input  logic [NUM_REQ*DATA_W-1:0] ReqSrcA,
  input  logic [NUM_REQ*DATA_W-1:0] ReqSrcB,
  input  logic [NUM_REQ*CTRL_W-1:0] ReqCtrl,
  output logic [DATA_W-1:0]         AluSrcA,
  output logic [DATA_W-1:0]         AluSrcB,
  output logic [CTRL_W-1:0]         AluControl,
  input  logic [DATA_W-1:0]         AluResult,
  input  logic                      AluZero,
  output logic                      RspValid,
  input  logic                      RspReady,
  output logic [DATA_W-1:0]         RspResult,
  output logic                      RspZero,
  output logic [ID_W-1:0]           RspId,
  output logic                      RspIllegal
);

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic              accept;

  logic [DATA_W-1:0] op_a, op_b;
  logic [CTRL_W-1:0] op_ctrl;
  logic [ID_W-1:0]   op_id;

  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_illegal;

  logic [DATA_W-1:0] sel_a, sel_b;
  logic [CTRL_W-1:0] sel_ctrl;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req        (ReqValid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (win_idx),
    .grant_any  (win_any)
  );

  // Route the winner's operands toward the op registers.
  always_comb begin
    sel_a    = ReqSrcA[int'(win_idx)*DATA_W +: DATA_W];
    sel_b    = ReqSrcB[int'(win_idx)*DATA_W +: DATA_W];
    sel_ctrl = ReqCtrl[int'(win_idx)*CTRL_W +: CTRL_W];
  end

  // Next state and the combinational accept; ReqReady only ever offered in IDLE.
  always_comb begin
    state_nxt = state;
    ReqReady  = '0;
    accept    = 1'b0;
    case (state)
      ARB_IDLE: begin
        ReqReady = grant;
        if (win_any) begin
          accept    = 1'b1;
          state_nxt = ARB_EXEC;
        end
      end
      ARB_EXEC: state_nxt = ARB_RESP;
      ARB_RESP: if (RspReady) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // State, op and response registers; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      last_grant  <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_ctrl     <= '0;
      op_id       <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_id      <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a       <= sel_a;
        op_b       <= sel_b;
        op_ctrl    <= sel_ctrl;
        op_id      <= win_idx;
        last_grant <= win_idx;
      end
      if (state == ARB_EXEC) begin
        rsp_result  <= AluResult;
        rsp_zero    <= AluZero;
        rsp_id      <= op_id;
        rsp_illegal <= (op_ctrl > CTRL_W'(ALU_OP_MAX));
      end
    end
  end

  // ALU inputs come straight from the op registers, so they hold between ops.
  assign AluSrcA    = op_a;
  assign AluSrcB    = op_b;
  assign AluControl = op_ctrl;

  assign RspValid   = (state == ARB_RESP);
  assign RspResult  = rsp_result;
  assign RspZero    = rsp_zero;
  assign RspId      = rsp_id;
  assign RspIllegal = rsp_illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the Alu* ports and a
// response scoreboard fed at accept time.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ReqValid, ReqReady;
  logic [63:0] ReqSrcA, ReqSrcB;
  logic [7:0]  ReqCtrl;
  logic [31:0] AluSrcA, AluSrcB, AluResult;
  logic [3:0]  AluControl;
  logic        AluZero;
  logic        RspValid, RspReady, RspZero, RspIllegal;
  logic [31:0] RspResult;
  logic [0:0]  RspId;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [0:0]  id;
    logic        ill;
  } rsp_t;

  rsp_t q[$];
  rsp_t e;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(2), .DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqSrcA(ReqSrcA), .ReqSrcB(ReqSrcB), .ReqCtrl(ReqCtrl),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluControl(AluControl),
    .AluResult(AluResult), .AluZero(AluZero),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspResult(RspResult), .RspZero(RspZero), .RspId(RspId), .RspIllegal(RspIllegal)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU
  assign AluResult = alu_f(AluSrcA, AluSrcB, AluControl);
  assign AluZero   = (AluResult == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    ReqSrcA[i*32 +: 32] = a;
    ReqSrcB[i*32 +: 32] = b;
    ReqCtrl[i*4 +: 4]   = c;
  endtask

  task automatic push(input int id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c);
    rsp_t r;
    r.res  = alu_f(a, b, c);
    r.zero = (r.res == 32'd0);
    r.id   = 1'(id);
    r.ill  = (c > 4'd6);
    q.push_back(r);
  endtask

  // Scoreboard: pop on every response handshake; reset drops in-flight expectations.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
    end else if (RspValid && RspReady) begin
      chk("sb_pending", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_result",  RspResult,  e.res);
        chk("sb_zero",    RspZero,    e.zero);
        chk("sb_id",      RspId,      e.id);
        chk("sb_illegal", RspIllegal, e.ill);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    ReqValid = '0;
    ReqSrcA  = '0;
    ReqSrcB  = '0;
    ReqCtrl  = '0;
    RspReady = 1'b1;
    repeat (2) tick();
    chk("rst_rspvalid", RspValid, 0);
    chk("rst_reqready", ReqReady, 0);
    chk("rst_alusrca",  AluSrcA, 0);
    chk("rst_aluctrl",  AluControl, 0);
    chk("rst_result",   RspResult, 0);
    chk("rst_id",       RspId, 0);
    reset = 1'b0;

    // Single ADD on req0: ready same cycle, response two cycles later.
    set_req(0, 32'd5, 32'd3, 4'd0);
    ReqValid = 2'b01;
    #1 chk("add_ready", ReqReady, 2'b01);
    push(0, 32'd5, 32'd3, 4'd0);
    tick();
    ReqValid = 2'b00;
    chk("add_exec_rspv", RspValid, 0);
    chk("add_exec_srca", AluSrcA, 5);
    chk("add_exec_srcb", AluSrcB, 3);
    tick();
    chk("add_rspv",   RspValid, 1);
    chk("add_result", RspResult, 8);
    chk("add_zero",   RspZero, 0);
    chk("add_id",     RspId, 0);
    chk("add_ill",    RspIllegal, 0);
    tick();
    chk("add_idle_rspv", RspValid, 0);

    // Shifts on req1: shift amount is B[4:0].
    set_req(1, 32'd1, 32'd35, 4'd5);
    ReqValid = 2'b10;
    #1 chk("sll_ready", ReqReady, 2'b10);
    push(1, 32'd1, 32'd35, 4'd5);
    tick();
    tick();
    chk("sll_result", RspResult, 8);
    chk("sll_id",     RspId, 1);
    set_req(1, 32'h8000_0000, 32'd31, 4'd6);
    tick();
    chk("srl_ready", ReqReady, 2'b10);
    push(1, 32'h8000_0000, 32'd31, 4'd6);
    tick();
    ReqValid = 2'b00;
    tick();
    chk("srl_result", RspResult, 1);
    tick();

    // Both valid every cycle: grants alternate starting from req0.
    set_req(0, 32'd7, 32'd7, 4'd1);
    set_req(1, 32'h0000_00F0, 32'h0000_000F, 4'd3);
    ReqValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("alt_ready", ReqReady, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k % 2 == 0) push(0, 32'd7, 32'd7, 4'd1);
      else            push(1, 32'h0000_00F0, 32'h0000_000F, 4'd3);
      tick();
      tick();
      chk("alt_id",     RspId, k % 2);
      chk("alt_zero",   RspZero, (k % 2 == 0) ? 1 : 0);
      chk("alt_result", RspResult, (k % 2 == 0) ? 32'd0 : 32'h0000_00FF);
      tick();
    end
    ReqValid = 2'b00;

    // Illegal op code: ALU forces 0, flagged illegal.
    set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    ReqValid = 2'b01;
    #1 chk("ill_ready", ReqReady, 2'b01);
    push(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    tick();
    ReqValid = 2'b00;
    tick();
    chk("ill_result", RspResult, 0);
    chk("ill_zero",   RspZero, 1);
    chk("ill_flag",   RspIllegal, 1);
    tick();

    // Backpressure: response held 10 cycles, nothing accepted meanwhile.
    RspReady = 1'b0;
    set_req(0, 32'd1, 32'd2, 4'd0);
    set_req(1, 32'h0000_FF00, 32'h0000_0FF0, 4'd4);
    ReqValid = 2'b11;
    #1 chk("bp_ready", ReqReady, 2'b10);
    push(1, 32'h0000_FF00, 32'h0000_0FF0, 4'd4);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_rspv",   RspValid, 1);
      chk("bp_result", RspResult, 32'h0000_F0F0);
      chk("bp_id",     RspId, 1);
      chk("bp_noacc",  ReqReady, 0);
      tick();
    end
    RspReady = 1'b1;
    tick();
    chk("bp_next_ready", ReqReady, 2'b01);
    push(0, 32'd1, 32'd2, 4'd0);
    tick();
    ReqValid = 2'b00;
    tick();
    chk("bp_next_result", RspResult, 3);
    chk("bp_next_id",     RspId, 0);
    tick();

    // Reset during EXEC discards the op; pointer returns to 0.
    set_req(0, 32'd9, 32'd4, 4'd1);
    ReqValid = 2'b01;
    #1 chk("rx_ready", ReqReady, 2'b01);
    push(0, 32'd9, 32'd4, 4'd1);
    tick();
    chk("rx_exec_srca", AluSrcA, 9);
    reset = 1'b1;
    tick();
    chk("rx_rspv", RspValid, 0);
    chk("rx_srca", AluSrcA, 0);
    reset = 1'b0;
    #1 chk("rx_regrant", ReqReady, 2'b01);
    push(0, 32'd9, 32'd4, 4'd1);
    tick();
    ReqValid = 2'b00;
    tick();
    chk("rx_result", RspResult, 5);
    tick();

    repeat (2) tick();
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
